// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: segment patterns (abcdefg,
// a in bit 6) and a width helper for the scan counters.
package seg7_pkg;

  localparam int unsigned SEG_W = 7;

  typedef logic [SEG_W-1:0] seg_t;

  localparam seg_t SEG_BLANK = 7'b0000000;
  localparam seg_t SEG_0     = 7'b1111110;
  localparam seg_t SEG_1     = 7'b0110000;
  localparam seg_t SEG_2     = 7'b1101101;
  localparam seg_t SEG_3     = 7'b1111001;
  localparam seg_t SEG_4     = 7'b0110011;
  localparam seg_t SEG_5     = 7'b1011011;
  localparam seg_t SEG_6     = 7'b1011111;
  localparam seg_t SEG_7     = 7'b1110000;
  localparam seg_t SEG_8     = 7'b1111111;
  localparam seg_t SEG_9     = 7'b1111011;
  localparam seg_t SEG_A     = 7'b1110111;
  localparam seg_t SEG_B     = 7'b0011111;
  localparam seg_t SEG_C     = 7'b1001110;
  localparam seg_t SEG_D     = 7'b0111101;
  localparam seg_t SEG_E     = 7'b1001111;
  localparam seg_t SEG_F     = 7'b1000111;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int unsigned idx_width(int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Value/decimal-point load port and display pin bundle of the scan driver.
interface seg7_scan_driver_if
  import seg7_pkg::*;
#(
  parameter int unsigned N_DIGITS = 4
);

  logic                  load;
  logic [4*N_DIGITS-1:0] din;
  logic [N_DIGITS-1:0]   dp_in;
  seg_t                  seg;
  logic                  dp;
  logic [N_DIGITS-1:0]   an;

  modport master (output load, din, dp_in, input seg, dp, an);
  modport slave  (input load, din, dp_in, output seg, dp, an);

endinterface

// File: rtl/seg7_decode.sv
// Nibble to 7-segment pattern; in BCD mode codes 10-15 decode to blank.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       hex,
  output seg_t       seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    case (nibble)
      4'h0: seg_c = SEG_0;
      4'h1: seg_c = SEG_1;
      4'h2: seg_c = SEG_2;
      4'h3: seg_c = SEG_3;
      4'h4: seg_c = SEG_4;
      4'h5: seg_c = SEG_5;
      4'h6: seg_c = SEG_6;
      4'h7: seg_c = SEG_7;
      4'h8: seg_c = SEG_8;
      4'h9: seg_c = SEG_9;
      4'hA: seg_c = hex ? SEG_A : SEG_BLANK;
      4'hB: seg_c = hex ? SEG_B : SEG_BLANK;
      4'hC: seg_c = hex ? SEG_C : SEG_BLANK;
      4'hD: seg_c = hex ? SEG_D : SEG_BLANK;
      4'hE: seg_c = hex ? SEG_E : SEG_BLANK;
      4'hF: seg_c = hex ? SEG_F : SEG_BLANK;
      default: seg_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit 7-segment scan driver with a one-cycle guard per digit slot.
// Define SEG7_LZB_EN to blank leading zero digits (digit 0 is never blanked).
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned N_DIGITS = 4,
  parameter int unsigned DIV      = 1000,
  parameter int unsigned HEX      = 0
) (
  input  logic             clk,
  input  logic             rst,
  seg7_scan_driver_if.slave bus
);

  localparam int unsigned IW = idx_width(N_DIGITS);
  localparam int unsigned CW = idx_width(DIV);
  localparam int unsigned VW = 4 * N_DIGITS;
  localparam logic        HEX_EN = (HEX != 0);

  logic [VW-1:0]       val_q, val_d;
  logic [N_DIGITS-1:0] dpr_q, dpr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  seg_t                seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [N_DIGITS-1:0] an_q, an_d;

  logic [3:0] nibble_c;
  seg_t       dec_c;
  logic       blank_c;

  assign nibble_c = 4'(val_q >> (32'(idx_q) * 4));

  seg7_decode u_decode (
    .nibble (nibble_c),
    .hex    (HEX_EN),
    .seg_c  (dec_c)
  );

`ifdef SEG7_LZB_EN
  logic [N_DIGITS-1:0] upper_zero_c;

  // upper_zero_c[i]: nibbles i..N_DIGITS-1 of the latched value are all zero.
  always_comb begin
    logic run;
    run          = 1'b1;
    upper_zero_c = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      run             = run & (val_q[4*i +: 4] == 4'h0);
      upper_zero_c[i] = run;
    end
  end

  assign blank_c = (idx_q != '0) && upper_zero_c[idx_q];
`else
  assign blank_c = 1'b0;
`endif

  // Prescaler, scan index, value latch and next output values.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    idx_d = idx_q;
    val_d = val_q;
    dpr_d = dpr_q;
    seg_d = SEG_BLANK;
    dp_d  = 1'b0;
    an_d  = '0;

    if (cnt_q == CW'(DIV - 1)) begin
      cnt_d = '0;
      idx_d = (idx_q == IW'(N_DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end

    if (bus.load) begin
      val_d = bus.din;
      dpr_d = bus.dp_in;
    end

    // cnt_q == 0 is the anti-ghosting guard: everything stays dark.
    if (cnt_q != '0) begin
      an_d  = N_DIGITS'(1) << idx_q;
      seg_d = blank_c ? SEG_BLANK : dec_c;
      dp_d  = dpr_q[idx_q];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_q <= '0;
      dpr_q <= '0;
      cnt_q <= '0;
      idx_q <= '0;
      seg_q <= SEG_BLANK;
      dp_q  <= 1'b0;
      an_q  <= '0;
    end else begin
      val_q <= val_d;
      dpr_q <= dpr_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
      an_q  <= an_d;
    end
  end

  assign bus.seg = seg_q;
  assign bus.dp  = dp_q;
  assign bus.an  = an_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench: a BCD and a HEX instance (N_DIGITS=4, DIV=4) share stimulus.
module tb_seg7_scan_driver;

  localparam logic [6:0] S0 = 7'b1111110;
  localparam logic [6:0] S3 = 7'b1111001;
  localparam logic [6:0] S5 = 7'b1011011;
  localparam logic [6:0] S7 = 7'b1110000;
  localparam logic [6:0] S8 = 7'b1111111;
  localparam logic [6:0] S9 = 7'b1111011;
  localparam logic [6:0] SA = 7'b1110111;
  localparam logic [6:0] SC = 7'b1001110;
  localparam logic [6:0] SD = 7'b0111101;
  localparam logic [6:0] SE = 7'b1001111;
  localparam logic [6:0] SF = 7'b1000111;
  localparam logic [6:0] BL = 7'b0000000;
`ifdef SEG7_LZB_EN
  localparam logic [6:0] ZB = BL;
`else
  localparam logic [6:0] ZB = S0;
`endif

  // Expected per-digit patterns packed as {digit3, digit2, digit1, digit0}.
  localparam logic [27:0] E_ZERO    = {ZB, ZB, ZB, S0};
  localparam logic [27:0] E_9A37_B  = {S9, BL, S3, S7};
  localparam logic [27:0] E_9A37_H  = {S9, SA, S3, S7};
  localparam logic [27:0] E_FEDC_B  = {BL, BL, BL, BL};
  localparam logic [27:0] E_FEDC_H  = {SF, SE, SD, SC};
  localparam logic [27:0] E_0050    = {ZB, ZB, S5, S0};
  localparam logic [27:0] E_0080    = {ZB, ZB, S8, S0};

  logic        clk;
  logic        rst;
  logic        load;
  logic [15:0] din;
  logic [3:0]  dp_in;

  int n_checks;
  int n_err;
  int pos;

  seg7_scan_driver_if #(.N_DIGITS(4)) bus_bcd ();
  seg7_scan_driver_if #(.N_DIGITS(4)) bus_hex ();

  assign bus_bcd.load  = load;
  assign bus_bcd.din   = din;
  assign bus_bcd.dp_in = dp_in;
  assign bus_hex.load  = load;
  assign bus_hex.din   = din;
  assign bus_hex.dp_in = dp_in;

  seg7_scan_driver #(.N_DIGITS(4), .DIV(4), .HEX(0)) u_bcd (
    .clk (clk),
    .rst (rst),
    .bus (bus_bcd)
  );

  seg7_scan_driver #(.N_DIGITS(4), .DIV(4), .HEX(1)) u_hex (
    .clk (clk),
    .rst (rst),
    .bus (bus_hex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d after reset)", tag, got, exp, pos);
    end
  endtask

  task automatic chk_dark(input string tag);
    chk({tag, "_an"},      32'(bus_bcd.an),  32'h0);
    chk({tag, "_seg_bcd"}, 32'(bus_bcd.seg), 32'h0);
    chk({tag, "_seg_hex"}, 32'(bus_hex.seg), 32'h0);
    chk({tag, "_dp"},      32'(bus_bcd.dp),  32'h0);
  endtask

  // Advance n edges; pos is the number of edges since reset release.
  task automatic run_cycles(input int n, input logic [27:0] eb, input logic [27:0] eh,
                            input logic [3:0] edp);
    for (int i = 0; i < n; i++) begin
      int p;
      int ix;
      @(posedge clk);
      #1;
      p  = pos;
      pos++;
      ix = (p / 4) % 4;
      if ((p % 4) == 0) begin
        chk_dark("guard");
      end else begin
        chk("an",      32'(bus_bcd.an),  32'(4'b0001 << ix));
        chk("an_hex",  32'(bus_hex.an),  32'(4'b0001 << ix));
        chk("seg_bcd", 32'(bus_bcd.seg), 32'(eb[7*ix +: 7]));
        chk("seg_hex", 32'(bus_hex.seg), 32'(eh[7*ix +: 7]));
        chk("dp",      32'(bus_bcd.dp),  32'(edp[ix]));
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    pos      = 0;
    rst      = 1'b1;
    load     = 1'b0;
    din      = '0;
    dp_in    = '0;

    #12;
    chk_dark("reset");

    @(posedge clk);
    #3;
    rst = 1'b0;
    pos = 0;

    // Scan order and guard cycles with an empty value.
    run_cycles(16, E_ZERO, E_ZERO, 4'b0000);

    // BCD vs hex decode, invalid BCD digit keeps its decimal point.
    load  = 1'b1;
    din   = 16'h9A37;
    dp_in = 4'b0100;
    run_cycles(1, E_ZERO, E_ZERO, 4'b0000);
    load  = 1'b0;
    run_cycles(16, E_9A37_B, E_9A37_H, 4'b0100);

    load  = 1'b1;
    din   = 16'hFEDC;
    dp_in = 4'b0000;
    run_cycles(1, E_9A37_B, E_9A37_H, 4'b0100);
    load  = 1'b0;
    run_cycles(16, E_FEDC_B, E_FEDC_H, 4'b0000);

    // Leading zeros: blanked only with SEG7_LZB_EN.
    load = 1'b1;
    din  = 16'h0050;
    run_cycles(1, E_FEDC_B, E_FEDC_H, 4'b0000);
    load = 1'b0;
    run_cycles(16, E_0050, E_0050, 4'b0000);

    load = 1'b1;
    din  = 16'h0000;
    run_cycles(1, E_0050, E_0050, 4'b0000);
    load = 1'b0;
    run_cycles(16, E_ZERO, E_ZERO, 4'b0000);

    // Mid-slot load on digit 1 (cnt=1); slot timing must not change.
    while ((pos % 16) != 5) run_cycles(1, E_ZERO, E_ZERO, 4'b0000);
    load = 1'b1;
    din  = 16'h0080;
    run_cycles(1, E_ZERO, E_ZERO, 4'b0000);
    load = 1'b0;
    run_cycles(4, E_0080, E_0080, 4'b0000);

    // Asynchronous reset while digit 2 is lit.
    #2;
    rst = 1'b1;
    #1;
    chk_dark("async_rst");
    @(posedge clk);
    #1;
    chk_dark("rst_held");
    #2;
    rst = 1'b0;
    pos = 0;
    run_cycles(8, E_ZERO, E_ZERO, 4'b0000);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
